buff_uart_host: RTL and testbench



---
 rtl/buff_uart_host.sv | 109 ++++++++++
 tb/tb_buff_uart_host.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/buff_uart_host.sv
// buff_uart_host: bus-side master that turns a TX byte stream and an RX byte stream
// into single-cycle register accesses on the buffered UART, polling its status first.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   tx_data/tx_valid/tx_ready   byte stream to transmit
//   rx_data/rx_valid/rx_ready   byte stream of received bytes (one-entry holding register)
//   read_enable/write_enable    one-cycle bus strobes, never together
//   active_address/data_in      bus address and write data, zero when no strobe
//   data_out                    bus read data, valid the cycle after read_enable
//   tx_count/rx_count           byte counters, present only with BUFF_UART_HOST_STATS_EN
module buff_uart_host #(
    parameter int width          = 8,
    parameter int address_width  = 4,
    parameter int rx_address     = 0,
    parameter int tx_address     = 0,
    parameter int status_address = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [width-1:0]         tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic [width-1:0]         rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     read_enable,
    output logic                     write_enable,
    output logic [address_width-1:0] active_address,
    output logic [width-1:0]         data_in,
    input  logic [width-1:0]         data_out,
    output logic [15:0]              tx_count,
    output logic [15:0]              rx_count
);
    typedef enum logic [2:0] {POLL, STATUS, WRITE, READ, CAPTURE} state_t;
    state_t state_q, state_d;
    logic last_rx_q, last_rx_d, served_q, served_d, rx_valid_q, rx_valid_d;
    logic [width-1:0] rx_data_q, rx_data_d;
    logic tx_go, rx_go, pick_rx;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= POLL;
            last_rx_q  <= 1'b0;
            served_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_rx_q  <= last_rx_d;
            served_q   <= served_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end
    // A tie goes to RX only once something has been served and that was a TX,
    // so the very first tie after reset goes to TX and later ties alternate.
    always_comb begin
        state_d    = POLL;
        last_rx_d  = last_rx_q;
        served_d   = served_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q && !rx_ready;
        tx_go      = tx_valid && !data_out[1];
        rx_go      = data_out[0] && !rx_valid_q;
        pick_rx    = rx_go && (!tx_go || (served_q && !last_rx_q));
        case (state_q)
            POLL:    state_d = STATUS;
            STATUS:  state_d = pick_rx ? READ : tx_go ? WRITE : POLL;
            WRITE: begin
                last_rx_d = 1'b0;
                served_d  = 1'b1;
            end
            READ:    state_d = CAPTURE;
            CAPTURE: begin
                rx_data_d  = data_out;
                rx_valid_d = 1'b1;
                last_rx_d  = 1'b1;
                served_d   = 1'b1;
            end
            default: state_d = POLL;
        endcase
    end
    // Strobes are masked by rst so the cycles under reset show no access.
    assign read_enable    = !rst && (state_q == POLL || state_q == READ);
    assign write_enable   = !rst && state_q == WRITE;
    assign tx_ready       = write_enable;
    assign active_address = (read_enable && state_q == POLL) ? address_width'(status_address)
                          : read_enable  ? address_width'(rx_address)
                          : write_enable ? address_width'(tx_address) : '0;
    assign data_in        = write_enable ? tx_data : '0;
    assign rx_valid       = rx_valid_q;
    assign rx_data        = rx_data_q;
`ifdef BUFF_UART_HOST_STATS_EN
    logic [15:0] tx_count_q, rx_count_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_count_q <= '0;
            rx_count_q <= '0;
        end else begin
            if (state_q == WRITE) tx_count_q <= tx_count_q + 16'd1;
            if (state_q == CAPTURE) rx_count_q <= rx_count_q + 16'd1;
        end
    end
    assign tx_count = tx_count_q;
    assign rx_count = rx_count_q;
`else
    assign tx_count = '0;
    assign rx_count = '0;
`endif
endmodule

// File: tb/tb_buff_uart_host.sv
// tb_buff_uart_host: randomized bench with a UART environment model and a transaction-level reference
module tb_buff_uart_host;
    localparam int DEPTH = 4;
    localparam logic [1:0] K_NONE = 2'd0, K_POLL = 2'd1, K_WRITE = 2'd2, K_READ = 2'd3;
`ifdef BUFF_UART_HOST_STATS_EN
    localparam logic [15:0] STATS = 16'd1;
`else
    localparam logic [15:0] STATS = 16'd0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic tx_valid = 1'b0;
    logic tx_ready;
    logic [7:0] rx_data;
    logic rx_valid;
    logic rx_ready = 1'b0;
    logic read_enable, write_enable;
    logic [3:0] active_address;
    logic [7:0] data_in;
    logic [7:0] data_out = '0;
    logic [15:0] tx_count, rx_count;
    always #5 clk = ~clk;
    buff_uart_host dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .read_enable(read_enable), .write_enable(write_enable),
        .active_address(active_address), .data_in(data_in), .data_out(data_out),
        .tx_count(tx_count), .rx_count(rx_count)
    );
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [1:0] exp_kind [8];
    bit is_st [8];
    bit arr [8];
    logic [7:0] arr_byte [8];
    bit m_rx_valid = 0;
    logic [7:0] m_rx_byte = '0;
    int last_kind = 0;
    logic [15:0] m_txc = '0, m_rxc = '0;
    bit tx_busy = 0;
    logic [7:0] rxq [$];
    int txq_n = 0;
    bit pend = 0;
    logic [7:0] pend_resp = '0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    task automatic run(input int ncyc, input int p_tx, input int p_push, input int p_drain,
                       input int p_ready, input bit rst_rd, input bit hold_rst);
        for (int c = 0; c < ncyc; c++) begin
            int i, j, k;
            logic [1:0] kind;
            logic [7:0] st;
            bit tx_go, rx_go;
            @(posedge clk);
            #1;
            cyc++;
            i = cyc % 8;
            j = (cyc + 1) % 8;
            k = (cyc + 2) % 8;
            if (arr[i]) begin
                m_rx_valid = 1;
                m_rx_byte = arr_byte[i];
                m_rxc += STATS;
                arr[i] = 0;
            end
            if ($urandom_range(99) < p_push && rxq.size() < 16) rxq.push_back(8'($urandom));
            if (txq_n > 0 && $urandom_range(99) < p_drain) txq_n--;
            data_out = pend ? pend_resp : 8'($urandom);
            if (!tx_busy && $urandom_range(99) < p_tx) begin
                tx_busy = 1;
                tx_data = 8'($urandom);
            end
            tx_valid = tx_busy;
            rx_ready = $urandom_range(99) < p_ready;
            rst = hold_rst || (rst_rd && exp_kind[i] == K_READ && $urandom_range(1) == 1);
            #1;
            kind = rst ? K_NONE : exp_kind[i];
            check("read_enable", 32'(read_enable), 32'(kind == K_POLL || kind == K_READ));
            check("write_enable", 32'(write_enable), 32'(kind == K_WRITE));
            check("tx_ready", 32'(tx_ready), 32'(kind == K_WRITE));
            check("active_address", 32'(active_address), (kind == K_POLL) ? 32'd1 : 32'd0);
            check("data_in", 32'(data_in), (kind == K_WRITE) ? 32'(tx_data) : 32'd0);
            check("rx_valid", 32'(rx_valid), 32'(m_rx_valid));
            check("rx_data", 32'(rx_data), 32'(m_rx_byte));
            check("tx_count", 32'(tx_count), 32'(m_txc));
            check("rx_count", 32'(rx_count), 32'(m_rxc));
            if (rst) begin
                for (int q = 0; q < 8; q++) begin
                    exp_kind[q] = K_NONE;
                    is_st[q] = 0;
                    arr[q] = 0;
                end
                exp_kind[j] = K_POLL;
                m_rx_valid = 0;
                m_rx_byte = '0;
                last_kind = 0;
                m_txc = '0;
                m_rxc = '0;
            end else begin
                if (kind == K_POLL) is_st[j] = 1;
                if (is_st[i]) begin
                    st = data_out;
                    tx_go = tx_valid && !st[1];
                    rx_go = st[0] && !m_rx_valid;
                    exp_kind[j] = (tx_go && (!rx_go || last_kind != 1)) ? K_WRITE
                                : rx_go ? K_READ : K_POLL;
                end
                if (kind == K_WRITE) begin
                    exp_kind[j] = K_POLL;
                    last_kind = 1;
                    tx_busy = 0;
                    m_txc += STATS;
                end
                if (kind == K_READ) begin
                    exp_kind[k] = K_POLL;
                    last_kind = 2;
                    arr[k] = 1;
                    arr_byte[k] = (rxq.size() != 0) ? rxq[0] : 8'h00;
                end
                if (m_rx_valid && rx_ready) m_rx_valid = 0;
            end
            exp_kind[i] = K_NONE;
            is_st[i] = 0;
            pend = read_enable;
            if (read_enable) begin
                if (active_address == 4'd1)
                    pend_resp = {6'($urandom), 1'(txq_n == DEPTH), 1'(rxq.size() != 0)};
                else if (rxq.size() != 0)
                    pend_resp = rxq.pop_front();
                else
                    pend_resp = 8'h00;
            end
            if (write_enable && txq_n < DEPTH) txq_n++;
        end
    endtask
    initial begin
        for (int q = 0; q < 8; q++) begin
            exp_kind[q] = K_NONE;
            is_st[q] = 0;
            arr[q] = 0;
            arr_byte[q] = '0;
        end
        run(3, 0, 0, 0, 0, 0, 1);
        run(600, 50, 30, 40, 50, 0, 0);
        run(150, 60, 50, 40, 0, 0, 0);
        run(50, 60, 50, 40, 100, 0, 0);
        run(200, 100, 20, 5, 80, 0, 0);
        run(200, 100, 100, 100, 100, 0, 0);
        run(400, 50, 40, 40, 60, 1, 0);
        run(3, 50, 40, 40, 60, 0, 1);
        run(150, 70, 60, 50, 70, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
